// File: rtl/seq_pkg.sv
// seq_pkg: opcode encoding, widths and flag bundle shared by the
// datapath and the sequence controller.
package seq_pkg;

  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam int INSTR_W = 12;

  typedef enum logic [3:0] {
    LOAD  = 4'd0,
    STORE = 4'd1,
    ADD   = 4'd2,
    SUB   = 4'd3,
    AND   = 4'd4,
    OR    = 4'd5,
    XOR   = 4'd6,
    NOT   = 4'd7,
    B     = 4'd8,
    BZ    = 4'd9,
    BN    = 4'd10,
    BV    = 4'd11,
    BC    = 4'd12
  } opcode_e;

  typedef struct packed {
    logic zf;
    logic nf;
    logic of;
    logic cf;
  } flags_t;

endpackage

// File: rtl/seq_alu.sv
// seq_alu: combinational ALU result and next flags for one opcode.
// Ports: op_i, a_i, b_i, flags_i in; r_o, flags_o, upd_o out.
module seq_alu
  import seq_pkg::*;
(
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  flags_t            flags_i,
  output logic [DATA_W-1:0] r_o,
  output flags_t            flags_o,
  output logic              upd_o
);

  logic [DATA_W:0]   ext;
  logic [DATA_W-1:0] res;

  always_comb begin
    ext     = '0;
    res     = a_i;
    flags_o = flags_i;
    upd_o   = 1'b1;
    case (op_i)
      LOAD: res = b_i;
      ADD: begin
        ext = {1'b0, a_i} + {1'b0, b_i};
        res = ext[DATA_W-1:0];
        flags_o.cf = ext[DATA_W];
        flags_o.of = (a_i[7] == b_i[7])
                   & (res[7] != a_i[7]);
      end
      SUB: begin
        // 9-bit borrow is set exactly when A < B
        ext = {1'b0, a_i} - {1'b0, b_i};
        res = ext[DATA_W-1:0];
        flags_o.cf = ext[DATA_W];
        flags_o.of = (a_i[7] != b_i[7])
                   & (res[7] != a_i[7]);
      end
      AND, OR, XOR, NOT: begin
        case (op_i)
          AND:     res = a_i & b_i;
          OR:      res = a_i | b_i;
          XOR:     res = a_i ^ b_i;
          default: res = ~a_i;
        endcase
        flags_o.cf = 1'b0;
        flags_o.of = 1'b0;
      end
      default: upd_o = 1'b0;
    endcase
    if (upd_o) begin
      flags_o.zf = (res == '0);
      flags_o.nf = res[7];
    end
    r_o = res;
  end

endmodule

// File: rtl/seq_datapath.sv
// seq_datapath: PC/IR/A/B/RDR/ALU_R/flag registers of the sequencer.
// Ports: CLK, RST, EN, control strobes, IR fields, flags, memory and
// I/O port. Optional PDR/PORT_OUT registers: SEQ_DP_IO_PORT_EN.
module seq_datapath
  import seq_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic               IR_EN,
  input  logic               A_EN,
  input  logic               B_EN,
  input  logic               PDR_EN,
  input  logic               PORT_EN,
  input  logic               PORT_RD,
  input  logic               PC_EN,
  input  logic               PC_LOAD,
  input  logic               ALU_EN,
  input  logic               ALU_OE,
  input  logic               RAM_OE,
  input  logic               RDR_EN,
  input  logic               RAM_CS,
  output logic [ADDR_W-1:0]  ADDR,
  output logic [3:0]         OPCODE,
  output logic               I_FLAG,
  output logic               ZF,
  output logic               NF,
  output logic               OF,
  output logic               CF,
  output logic [ADDR_W-1:0]  MEM_ADDR,
  input  logic [INSTR_W-1:0] MEM_RDATA,
  output logic [DATA_W-1:0]  MEM_WDATA,
  output logic               MEM_WE,
  input  logic [DATA_W-1:0]  PORT_IN,
  output logic [DATA_W-1:0]  PORT_OUT
);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [DATA_W-1:0]  rdr_q, rdr_d;
  logic [DATA_W-1:0]  alu_q, alu_d;
  flags_t             flg_q, flg_d;

  logic [DATA_W-1:0]  alu_r;
  flags_t             alu_f;
  logic               alu_upd;

  assign OPCODE = ir_q[11:8];
  assign I_FLAG = ir_q[7];
  assign ADDR   = ir_q[6:0];

  assign ZF = flg_q.zf;
  assign NF = flg_q.nf;
  assign OF = flg_q.of;
  assign CF = flg_q.cf;

  assign MEM_ADDR  = IR_EN ? pc_q : ADDR;
  assign MEM_WDATA = a_q;
  assign MEM_WE    = RAM_CS & ~RAM_OE & ~RST;

  seq_alu u_alu (
    .op_i    (OPCODE),
    .a_i     (a_q),
    .b_i     (b_q),
    .flags_i (flg_q),
    .r_o     (alu_r),
    .flags_o (alu_f),
    .upd_o   (alu_upd)
  );

  always_comb begin
    pc_d = pc_q;
    if (PC_LOAD)    pc_d = ADDR;
    else if (PC_EN) pc_d = pc_q + 1'b1;

    ir_d  = IR_EN ? MEM_RDATA : ir_q;
    rdr_d = (RDR_EN & RAM_CS & RAM_OE)
          ? MEM_RDATA[DATA_W-1:0] : rdr_q;

    a_d = a_q;
    if (A_EN) a_d = ALU_OE ? alu_q : rdr_q;

    b_d = b_q;
    if (B_EN) b_d = I_FLAG ? {1'b0, ADDR} : rdr_q;

    alu_d = alu_q;
    flg_d = flg_q;
    if (ALU_EN & alu_upd) begin
      alu_d = alu_r;
      flg_d = alu_f;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q  <= '0;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      rdr_q <= '0;
      alu_q <= '0;
      flg_q <= '0;
    end else if (EN) begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      a_q   <= a_d;
      b_q   <= b_d;
      rdr_q <= rdr_d;
      alu_q <= alu_d;
      flg_q <= flg_d;
    end
  end

`ifdef SEQ_DP_IO_PORT_EN
  logic [DATA_W-1:0] pdr_q;
  logic [DATA_W-1:0] pout_q;
  logic              unused_io;

  // PDR has no reader inside the datapath yet
  assign unused_io = ^pdr_q;
  assign PORT_OUT  = pout_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pdr_q  <= '0;
      pout_q <= '0;
    end else if (EN) begin
      if (PDR_EN & PORT_RD)  pdr_q  <= PORT_IN;
      if (PORT_EN & ~PORT_RD) pout_q <= a_q;
    end
  end
`else
  logic unused_io;

  assign unused_io = ^{PDR_EN, PORT_EN, PORT_RD, PORT_IN};
  assign PORT_OUT  = '0;
`endif

endmodule

// File: tb/tb_seq_datapath.sv
// tb_seq_datapath: directed scenarios plus randomized strobes,
// checked against an arithmetic model of the datapath registers.
module tb_seq_datapath;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b1;
  logic        IR_EN = 0, A_EN = 0, B_EN = 0;
  logic        PDR_EN = 0, PORT_EN = 0, PORT_RD = 0;
  logic        PC_EN = 0, PC_LOAD = 0;
  logic        ALU_EN = 0, ALU_OE = 0;
  logic        RAM_OE = 0, RDR_EN = 0, RAM_CS = 0;
  logic [6:0]  ADDR;
  logic [3:0]  OPCODE;
  logic        I_FLAG, ZF, NF, OF, CF;
  logic [6:0]  MEM_ADDR;
  logic [11:0] MEM_RDATA = '0;
  logic [7:0]  MEM_WDATA;
  logic        MEM_WE;
  logic [7:0]  PORT_IN = '0;
  logic [7:0]  PORT_OUT;

  int n_cmp = 0;
  int n_fail = 0;

  seq_datapath dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .IR_EN(IR_EN), .A_EN(A_EN), .B_EN(B_EN),
    .PDR_EN(PDR_EN), .PORT_EN(PORT_EN),
    .PORT_RD(PORT_RD), .PC_EN(PC_EN),
    .PC_LOAD(PC_LOAD), .ALU_EN(ALU_EN),
    .ALU_OE(ALU_OE), .RAM_OE(RAM_OE),
    .RDR_EN(RDR_EN), .RAM_CS(RAM_CS),
    .ADDR(ADDR), .OPCODE(OPCODE), .I_FLAG(I_FLAG),
    .ZF(ZF), .NF(NF), .OF(OF), .CF(CF),
    .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA),
    .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE),
    .PORT_IN(PORT_IN), .PORT_OUT(PORT_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---- reference model (plain integers) ----
  int m_pc, m_ir, m_a, m_b, m_rdr, m_r;
  int m_zf, m_nf, m_of, m_cf, m_pout;
  int t_op, t_ifl, t_addr;
  int n_pc, n_ir, n_a, n_b, n_rdr, n_r, n_pout;
  int n_zf, n_nf, n_of, n_cf;
  int sum, sa, sb, s;
  logic t_upd;

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  initial begin
    m_pc = 0; m_ir = 0; m_a = 0; m_b = 0; m_rdr = 0;
    m_r = 0; m_zf = 0; m_nf = 0; m_of = 0; m_cf = 0;
    m_pout = 0;
  end

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_pc = 0; m_ir = 0; m_a = 0; m_b = 0; m_rdr = 0;
      m_r = 0; m_zf = 0; m_nf = 0; m_of = 0; m_cf = 0;
      m_pout = 0;
    end else if (EN) begin
      t_op   = m_ir / 256;
      t_ifl  = (m_ir / 128) % 2;
      t_addr = m_ir % 128;
      if (PC_LOAD)    n_pc = t_addr;
      else if (PC_EN) n_pc = (m_pc + 1) % 128;
      else            n_pc = m_pc;
      n_ir  = IR_EN ? int'(MEM_RDATA) : m_ir;
      n_rdr = (RDR_EN && RAM_CS && RAM_OE)
            ? int'(MEM_RDATA) % 256 : m_rdr;
      n_a = A_EN ? (ALU_OE ? m_r : m_rdr) : m_a;
      n_b = B_EN ? (t_ifl == 1 ? t_addr : m_rdr) : m_b;
      n_pout = (PORT_EN && !PORT_RD) ? m_a : m_pout;
      n_r = m_r; n_zf = m_zf; n_nf = m_nf;
      n_of = m_of; n_cf = m_cf;
      t_upd = 1'b0;
      if (ALU_EN) begin
        t_upd = 1'b1;
        sa = sx(m_a);
        sb = sx(m_b);
        case (t_op)
          0: n_r = m_b;
          2: begin
            sum = m_a + m_b;
            n_r = sum % 256;
            n_cf = (sum > 255) ? 1 : 0;
            s = sa + sb;
            n_of = (s > 127 || s < -128) ? 1 : 0;
          end
          3: begin
            n_r = (m_a - m_b + 256) % 256;
            n_cf = (m_a < m_b) ? 1 : 0;
            s = sa - sb;
            n_of = (s > 127 || s < -128) ? 1 : 0;
          end
          4: begin n_r = m_a & m_b; n_cf = 0; n_of = 0; end
          5: begin n_r = m_a | m_b; n_cf = 0; n_of = 0; end
          6: begin n_r = m_a ^ m_b; n_cf = 0; n_of = 0; end
          7: begin n_r = 255 - m_a; n_cf = 0; n_of = 0; end
          default: t_upd = 1'b0;
        endcase
        if (t_upd) begin
          n_zf = (n_r == 0) ? 1 : 0;
          n_nf = (n_r >= 128) ? 1 : 0;
        end
      end
      m_pc = n_pc; m_ir = n_ir; m_rdr = n_rdr;
      m_a = n_a; m_b = n_b; m_r = n_r; m_pout = n_pout;
      m_zf = n_zf; m_nf = n_nf; m_of = n_of; m_cf = n_cf;
    end
  end

  // ---- compare process ----
  always @(negedge CLK) begin
    chk("OPCODE", OPCODE, m_ir / 256);
    chk("I_FLAG", I_FLAG, (m_ir / 128) % 2);
    chk("ADDR", ADDR, m_ir % 128);
    chk("MEM_ADDR", MEM_ADDR, IR_EN ? m_pc : m_ir % 128);
    chk("MEM_WDATA", MEM_WDATA, m_a);
    chk("MEM_WE", MEM_WE, (!RST && RAM_CS && !RAM_OE) ? 1 : 0);
    chk("FLAGS", {ZF, NF, OF, CF},
        m_zf * 8 + m_nf * 4 + m_of * 2 + m_cf);
`ifdef SEQ_DP_IO_PORT_EN
    chk("PORT_OUT", PORT_OUT, m_pout);
`else
    chk("PORT_OUT", PORT_OUT, 0);
`endif
  end

  // ---- stimulus helpers ----
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    {IR_EN, A_EN, B_EN, PDR_EN, PORT_EN, PORT_RD} = '0;
    {PC_EN, PC_LOAD, ALU_EN, ALU_OE} = '0;
    {RAM_OE, RDR_EN, RAM_CS} = '0;
    EN = 1'b1;
  endtask

  task automatic ld_ir(input logic [11:0] v);
    idle();
    MEM_RDATA = v;
    IR_EN = 1'b1;
    step();
    idle();
  endtask

  task automatic ld_rdr(input logic [7:0] v);
    idle();
    MEM_RDATA = {4'h0, v};
    RAM_CS = 1'b1; RAM_OE = 1'b1; RDR_EN = 1'b1;
    step();
    idle();
  endtask

  task automatic ld_a(input logic [7:0] v);
    ld_rdr(v);
    A_EN = 1'b1;
    step();
    idle();
  endtask

  task automatic peek_pc(input string nm, input logic [6:0] e);
    EN = 1'b0;
    IR_EN = 1'b1;
    #1;
    chk(nm, MEM_ADDR, e);
    IR_EN = 1'b0;
    EN = 1'b1;
  endtask

  logic [15:0] rb;

  initial begin
    idle();
    step();
    step();
    // reset state, write strobe masked by reset
    RAM_CS = 1'b1;
    #1;
    chk("rst_we", MEM_WE, 0);
    chk("rst_op", OPCODE, 0);
    chk("rst_addr", ADDR, 0);
    chk("rst_flags", {ZF, NF, OF, CF}, 0);
    chk("rst_a", MEM_WDATA, 0);
    idle();
    RST = 1'b0;
    step();

    // fetch
    MEM_RDATA = 12'h2C5;
    IR_EN = 1'b1; PC_EN = 1'b1;
    step();
    idle();
    chk("fetch_op", OPCODE, 2);
    chk("fetch_i", I_FLAG, 1);
    chk("fetch_addr", ADDR, 7'h45);
    peek_pc("fetch_pc", 7'd1);

    // immediate ADD 7F + 1
    ld_a(8'h7F);
    ld_ir(12'h281);
    B_EN = 1'b1; step(); idle();
    ALU_EN = 1'b1; step(); idle();
    chk("add_flags", {ZF, NF, OF, CF}, 4'b0110);
    A_EN = 1'b1; ALU_OE = 1'b1; step(); idle();
    chk("add_r", MEM_WDATA, 8'h80);

    // SUB 3 - 5
    ld_ir(12'h300);
    ld_rdr(8'd5);
    B_EN = 1'b1; step(); idle();
    ld_a(8'd3);
    ALU_EN = 1'b1; step(); idle();
    chk("sub_flags", {ZF, NF, OF, CF}, 4'b0101);
    A_EN = 1'b1; ALU_OE = 1'b1; step(); idle();
    chk("sub_r", MEM_WDATA, 8'hFE);

    // PC wrap and load priority
    ld_ir(12'h07F);
    PC_LOAD = 1'b1; step(); idle();
    peek_pc("pc_127", 7'h7F);
    PC_EN = 1'b1; step(); idle();
    peek_pc("pc_wrap", 7'h00);
    ld_ir(12'h010);
    PC_LOAD = 1'b1; PC_EN = 1'b1; step(); idle();
    peek_pc("pc_load", 7'h10);

    // STORE
    ld_ir(12'h12A);
    ld_a(8'hA5);
    RAM_CS = 1'b1; RAM_OE = 1'b0;
    #1;
    chk("st_we", MEM_WE, 1);
    chk("st_wdata", MEM_WDATA, 8'hA5);
    chk("st_addr", MEM_ADDR, 7'h2A);
    step();
    idle();

    // async reset between edges
    ld_ir(12'h080);
    B_EN = 1'b1; step(); idle();
    ALU_EN = 1'b1; step(); idle();
    ld_a(8'h33);
    chk("pre_a", MEM_WDATA, 8'h33);
    chk("pre_zf", ZF, 1);
    #1 RST = 1'b1;
    #1;
    chk("arst_a", MEM_WDATA, 0);
    chk("arst_zf", ZF, 0);
    RST = 1'b0;
    // EN=0 holds everything
    EN = 1'b0;
    MEM_RDATA = 12'h577;
    IR_EN = 1'b1; PC_EN = 1'b1;
    step();
    step();
    chk("hold_op", OPCODE, 0);
    chk("hold_addr", ADDR, 0);
    IR_EN = 1'b0;
    PC_EN = 1'b0;
    peek_pc("hold_pc", 7'd0);
    idle();

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      rb = 16'($urandom);
      EN      = (($urandom % 8) != 0);
      IR_EN   = rb[0];  A_EN    = rb[1];
      B_EN    = rb[2];  PDR_EN  = rb[3];
      PORT_EN = rb[4];  PORT_RD = rb[5];
      PC_EN   = rb[6];  PC_LOAD = rb[7] & rb[8];
      ALU_EN  = rb[9];  ALU_OE  = rb[10];
      RAM_OE  = rb[11]; RDR_EN  = rb[12];
      RAM_CS  = rb[13];
      MEM_RDATA = 12'($urandom);
      PORT_IN   = 8'($urandom);
      if (($urandom % 50) == 0) begin
        #2 RST = 1'b1;
        #1 RST = 1'b0;
      end
      step();
    end
    idle();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
